// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 scan-code set 2 decoder: scan byte
// constants, the prefix-collapsing FSM encoding and event field positions.
package kbd_pkg;

  // Prefix and special scan bytes (set 2)
  localparam logic [7:0] SC_E0         = 8'hE0;
  localparam logic [7:0] SC_E1         = 8'hE1;
  localparam logic [7:0] SC_F0         = 8'hF0;
  localparam logic [7:0] SC_LSHIFT     = 8'h12;
  localparam logic [7:0] SC_RSHIFT     = 8'h59;
  localparam logic [7:0] SC_CTRL       = 8'h14;
  localparam logic [7:0] SC_ALT        = 8'h11;
  localparam logic [7:0] SC_CAPS       = 8'h58;
  localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;
  localparam logic [7:0] SC_BAT_OK     = 8'hAA;
  localparam logic [7:0] SC_ACK        = 8'hFA;
  localparam logic [7:0] SC_ECHO       = 8'hEE;
  localparam logic [7:0] SC_ERR0       = 8'hFC;
  localparam logic [7:0] SC_ERR1       = 8'hFD;
  localparam logic [7:0] SC_OVR0       = 8'h00;
  localparam logic [7:0] SC_OVR1       = 8'hFF;

  // Bytes the Pause key sends after its leading E1
  localparam logic [2:0] PAUSE_SKIP    = 3'd7;

  // Event word layout: {ext, brk, code[7:0]}
  localparam int EV_W   = 10;
  localparam int EV_EXT = 9;
  localparam int EV_BRK = 8;

  // mod_o bit positions
  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_LCTRL  = 2;
  localparam int MOD_RCTRL  = 3;
  localparam int MOD_LALT   = 4;
  localparam int MOD_RALT   = 5;
  localparam int MOD_CAPS   = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_E0    = 3'd1,
    ST_F0    = 3'd2,
    ST_E0F0  = 3'd3,
    ST_PAUSE = 3'd4
  } kbd_state_e;

endpackage

// File: rtl/kbd_event_fifo.sv
// First-word-fall-through event FIFO. Pop while empty is ignored; a push
// while full is dropped and flagged unless a pop frees a slot that cycle.
module kbd_event_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         ovf_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign ovf_o   = push_i && full && !do_pop;
  // Head is forced to zero when empty so the output is clean out of reset
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed since reads are masked while empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 set 2 scan-code decoder: folds E0/F0/E1 prefixes into single key
// events, tracks modifier and caps-lock state, and queues events in a FIFO.
module kbd_scan_decoder
  import kbd_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            rx_stb_i,
  input  logic [7:0]      scan_code_i,
  input  logic            rd_stb_i,
  output logic [EV_W-1:0] event_o,
  output logic            event_valid_o,
  output logic            overflow_o,
  input  logic            clr_ovf_i,
  output logic [6:0]      mod_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  kbd_state_e      state_q, state_d;
  logic [2:0]      skip_q, skip_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [6:0]      mod_q, mod_d;
  logic            caps_held_q, caps_held_d;
  logic            ovf_q, ovf_d;
  logic            push;
  logic [EV_W-1:0] ev;
  logic            dec_ovf, fifo_ovf, fifo_empty;

  // Prefix FSM, timeout and modifier tracking
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    tmo_d       = '0;
    mod_d       = mod_q;
    caps_held_d = caps_held_q;
    push        = 1'b0;
    ev          = '0;
    dec_ovf     = 1'b0;
    if (rx_stb_i) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code_i == SC_E0)      state_d = ST_E0;
          else if (scan_code_i == SC_F0) state_d = ST_F0;
          else if (scan_code_i == SC_E1) begin
            state_d = ST_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (scan_code_i == SC_OVR0 || scan_code_i == SC_OVR1) dec_ovf = 1'b1;
          else if (scan_code_i == SC_BAT_OK || scan_code_i == SC_ACK ||
                   scan_code_i == SC_ECHO || scan_code_i == SC_ERR0 ||
                   scan_code_i == SC_ERR1) push = 1'b0;
          else begin
            push = 1'b1;
            ev   = {1'b0, 1'b0, scan_code_i};
          end
        end
        ST_E0: begin
          if (scan_code_i == SC_F0) state_d = ST_E0F0;
          else begin
            state_d = ST_IDLE;
            if (scan_code_i != SC_FAKE_SHIFT) begin
              push = 1'b1;
              ev   = {1'b1, 1'b0, scan_code_i};
            end
          end
        end
        ST_F0: begin
          state_d = ST_IDLE;
          push    = 1'b1;
          ev      = {1'b0, 1'b1, scan_code_i};
        end
        ST_E0F0: begin
          state_d = ST_IDLE;
          if (scan_code_i != SC_FAKE_SHIFT) begin
            push = 1'b1;
            ev   = {1'b1, 1'b1, scan_code_i};
          end
        end
        ST_PAUSE: begin
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
            skip_d  = '0;
            push    = 1'b1;
            ev      = {1'b1, 1'b0, SC_E1};
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Abandon a half-received sequence if the keyboard goes quiet
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) state_d = ST_IDLE;
      else tmo_d = tmo_q + 1'b1;
    end

    if (push) begin
      if (!ev[EV_EXT]) begin
        case (ev[7:0])
          SC_LSHIFT: mod_d[MOD_LSHIFT] = !ev[EV_BRK];
          SC_RSHIFT: mod_d[MOD_RSHIFT] = !ev[EV_BRK];
          SC_CTRL:   mod_d[MOD_LCTRL]  = !ev[EV_BRK];
          SC_ALT:    mod_d[MOD_LALT]   = !ev[EV_BRK];
          SC_CAPS: begin
            // Toggle once per physical press; typematic repeats are ignored
            if (ev[EV_BRK]) caps_held_d = 1'b0;
            else if (!caps_held_q) begin
              mod_d[MOD_CAPS] = !mod_q[MOD_CAPS];
              caps_held_d     = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (ev[7:0])
          SC_CTRL: mod_d[MOD_RCTRL] = !ev[EV_BRK];
          SC_ALT:  mod_d[MOD_RALT]  = !ev[EV_BRK];
          default: ;
        endcase
      end
    end

    // Sticky overflow; a new set beats a simultaneous clear
    if (dec_ovf || fifo_ovf) ovf_d = 1'b1;
    else if (clr_ovf_i)      ovf_d = 1'b0;
    else                     ovf_d = ovf_q;
  end

  // Decoder state registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      tmo_q       <= '0;
      mod_q       <= '0;
      caps_held_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      mod_q       <= mod_d;
      caps_held_q <= caps_held_d;
      ovf_q       <= ovf_d;
    end
  end

  kbd_event_fifo #(
    .DEPTH (DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  (ev),
    .pop_i   (rd_stb_i),
    .data_o  (event_o),
    .empty_o (fifo_empty),
    .ovf_o   (fifo_ovf)
  );

  assign event_valid_o = !fifo_empty;
  assign overflow_o    = ovf_q;
  assign mod_o         = mod_q;

endmodule

// File: doc/kbd_scan_decoder.md
Name: kbd_scan_decoder

Overview:
- Sits directly downstream of PS2_RX and consumes its rx_stb/scan_code byte stream (scan code set 2).
- Collapses the E0, F0 and E1 prefix sequences into single key events.
- Tracks modifier and caps-lock state.
- Buffers events in a first-word-fall-through FIFO that the CPU-side keyboard register interface reads.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT_CYC, 2500000: clk_i cycles with no rx_stb_i while mid-sequence before the decoder aborts to IDLE (25 ms at 100 MHz).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous, active-low reset
- rx_stb_i  in  1  one-cycle strobe from PS2_RX: byte valid
- scan_code_i  in  8  byte from PS2_RX, valid while rx_stb_i
- rd_stb_i  in  1  one-cycle pop of the FIFO head
- event_o  out  10  FIFO head: {ext, brk, code[7:0]}
- event_valid_o  out  1  FIFO not empty
- overflow_o  out  1  sticky error flag
- clr_ovf_i  in  1  clears overflow_o
- mod_o  out  7  {caps_lock, ralt, lalt, rctrl, lctrl, rshift, lshift}

Behaviour:
- Interface: one clock, clk_i. Reset rst_n_i is synchronous and active-low.
- Reset values:
  - event_o = 0, event_valid_o = 0, overflow_o = 0, mod_o = 0.
  - FIFO empty, state = IDLE, timeout counter = 0, caps_held = 0.
  - Reset asserted mid-sequence discards any partial prefix.
- FSM states: IDLE, E0, F0, E0F0, PAUSE. Transitions happen only on rx_stb_i.
- IDLE:
  - E0 -> E0; F0 -> F0; E1 -> PAUSE with skip count = 7.
  - 00 or FF (keyboard overrun): set overflow_o, stay in IDLE.
  - AA, FA, EE, FC, FD: dropped.
  - Any other byte: push {0,0,byte}.
- E0: F0 -> E0F0; 12 (fake shift) -> drop, go to IDLE; any other byte -> push {1,0,byte}, go to IDLE.
- F0: push {0,1,byte}, go to IDLE.
- E0F0: 12 -> drop, go to IDLE; any other byte -> push {1,1,byte}, go to IDLE.
- PAUSE:
  - Decrement the skip count on each byte.
  - When it reaches 0, push {1,0,8'hE1} and go to IDLE.
  - Pause has no break event.
- Timeout:
  - The counter runs in any state other than IDLE and resets on every rx_stb_i.
  - At TIMEOUT_CYC-1 the FSM goes to IDLE with no push.
- Modifiers update in the same cycle as the push; the new value is visible on mod_o the next cycle.
  - 12 -> lshift; 59 -> rshift; 14 -> lctrl; E0 14 -> rctrl; 11 -> lalt; E0 11 -> ralt.
  - A make sets the bit; a break clears it.
- Caps lock (non-extended code 58):
  - On a make with caps_held = 0, toggle caps_lock and set caps_held.
  - On a break, clear caps_held.
  - Typematic repeat makes therefore do not toggle.
- FIFO:
  - First-word fall-through. An event pushed in cycle N appears on event_o / event_valid_o in cycle N+1.
  - rd_stb_i while empty: ignored.
  - Push while full without a pop: event dropped, overflow_o set.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the new event is written and event_valid_o = 1 next cycle; the pop is ignored.
  - Pointers are log2(DEPTH) bits wide plus a count or wrap bit, and wrap modulo DEPTH.
- overflow_o:
  - Cleared by clr_ovf_i.
  - If a set condition and clr_ovf_i occur in the same cycle, set wins.
- rx_stb_i and rd_stb_i are independent and may coincide in any cycle.

Decomposition:
- Shared package kbd_pkg holds:
  - scan constants: SC_E0, SC_E1, SC_F0, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT, SC_CAPS, SC_FAKE_SHIFT, SC_BAT_OK, SC_ACK, SC_ECHO, SC_ERR0/1, SC_OVR0/1;
  - the FSM state encoding;
  - the event field-position constants.
- One sub-module, kbd_event_fifo: parameterized synchronous FWFT FIFO with push, pop, full, empty and overflow-on-push-while-full.

Test Plan:
- A make/break: bytes 1C, F0 1C with gaps -> events {0,0,1C} then {0,1,1C}; event_valid_o 1 cycle after each completing strobe; mod_o = 0.
- Right ctrl: E0 14, then E0 F0 14 -> events {1,0,14} and {1,1,14}; mod_o rctrl = 1 between them, 0 after; lctrl stays 0.
- Caps typematic: 58, 58, 58, F0 58, then 58 -> caps_lock goes 1 after the first make, stays 1 through the repeats, goes 0 after the make following the break; 5 events queued.
- Pause plus fake shift: E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,E1}. Then E0 12 E0 7C -> single event {1,0,7C}; lshift stays 0.
- Overflow: push 17 events with no reads -> 16 held, overflow_o = 1. Next, with FIFO full, drive rd_stb_i coincident with a completing strobe -> count stays 16, head advances, no loss. clr_ovf_i -> overflow_o = 0.
- Timeout/reset: send F0, idle TIMEOUT_CYC cycles, then 1C -> event {0,0,1C} (no break). Send E0 then assert rst_n_i low for 1 cycle -> FIFO empty, mod_o = 0; the following 1C yields {0,0,1C}.
